// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits MSB-first, STOP_BITS stop bits, valid/ready input.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       send_byte,
    output logic       ready,
    output logic       bit_out,
    output logic       busy,
    output logic       sent_byte
);

    localparam int unsigned       CNT_W     = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]        STOP_LAST = 2'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_next;
    logic [7:0]       shift_reg, shift_next;
    logic [CNT_W-1:0] clk_cnt, cnt_next;
    logic [2:0]       bit_idx, idx_next;
    logic [1:0]       stop_cnt, stop_next;
    logic             bit_next, busy_next, sent_next;
    logic             bit_done;
`ifdef UART_TX_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    assign bit_done = (clk_cnt == CNT_LAST);
    assign ready    = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            stop_cnt  <= '0;
            bit_out   <= 1'b1;
            busy      <= 1'b0;
            sent_byte <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            clk_cnt   <= cnt_next;
            bit_idx   <= idx_next;
            stop_cnt  <= stop_next;
            bit_out   <= bit_next;
            busy      <= busy_next;
            sent_byte <= sent_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        cnt_next   = clk_cnt;
        idx_next   = bit_idx;
        stop_next  = stop_cnt;
        sent_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        // Bit-period counter restarts at every bit boundary; frozen while idle.
        if (state != IDLE)
            cnt_next = bit_done ? '0 : clk_cnt + 1'b1;
        case (state)
            IDLE: begin
                if (send_byte) begin
                    shift_next = data_in;
                    cnt_next   = '0;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^data_in;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    idx_next   = 3'd7;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_next = {shift_reg[6:0], 1'b0};
                    idx_next   = bit_idx - 1'b1;
                    if (bit_idx == 3'd0) begin
                        stop_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done)
                    state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_next = IDLE;
                        sent_next  = 1'b1;
                    end else begin
                        stop_next = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is computed from the next state so bit_out can be a plain register.
    always_comb begin
        bit_next  = 1'b1;
        busy_next = (state_next != IDLE);
        case (state_next)
            START:   bit_next = 1'b0;
            DATA:    bit_next = shift_next[7];
`ifdef UART_TX_PARITY_EN
            PARITY:  bit_next = parity_next;
`endif
            default: bit_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: default 1-clock/1-stop instance and a
// 4-clock/2-stop instance; parity checks apply when UART_TX_PARITY_EN is defined.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LEN1 = 10 + PAR;
    localparam int LEN2 = (11 + PAR) * 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d1, d2;
    logic       s1, s2;
    logic       r1, b1, y1, t1;
    logic       r2, b2, y2, t2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_transmitter dut1 (
        .clk(clk), .rst(rst), .data_in(d1), .send_byte(s1),
        .ready(r1), .bit_out(b1), .busy(y1), .sent_byte(t1)
    );

    uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .data_in(d2), .send_byte(s2),
        .ready(r2), .bit_out(b2), .busy(y2), .sent_byte(t2)
    );

    // Expected line level for frame bit position idx (0 = start bit).
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[8 - idx];
        if (PAR == 1 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; s1 = 1'b0; s2 = 1'b0; d1 = 8'h00; d2 = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({b1, y1, t1, r1} !== 4'b1001) begin
                n_fail++;
                $display("FAIL reset_idle_dut1 cycle %0d: bit/busy/sent/ready=%b expected 1001", i, {b1, y1, t1, r1});
            end
            n_checks++;
            if ({b2, y2, t2, r2} !== 4'b1001) begin
                n_fail++;
                $display("FAIL reset_idle_dut2 cycle %0d: bit/busy/sent/ready=%b expected 1001", i, {b2, y2, t2, r2});
            end
        end
    endtask

    task automatic test_default_frame();
        d1 = 8'hA5; s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0; d1 = 8'h00;
        for (int i = 0; i < LEN1; i++) begin
            n_checks++;
            if ({b1, y1, t1, r1} !== {frame_bit(8'hA5, i), 3'b100}) begin
                n_fail++;
                $display("FAIL frame_A5 cycle %0d: bit/busy/sent/ready=%b expected %b", i, {b1, y1, t1, r1}, {frame_bit(8'hA5, i), 3'b100});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({b1, y1, t1, r1} !== 4'b1011) begin
            n_fail++;
            $display("FAIL frame_A5_done: bit/busy/sent/ready=%b expected 1011", {b1, y1, t1, r1});
        end
        @(negedge clk);
        n_checks++;
        if (t1 !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_A5_pulse_width: sent_byte=%b expected 0", t1);
        end
    endtask

    task automatic test_slow_frame();
        d2 = 8'h81; s2 = 1'b1;
        @(negedge clk);
        s2 = 1'b0; d2 = 8'h00;
        for (int i = 0; i < LEN2; i++) begin
            n_checks++;
            if ({b2, y2, t2} !== {frame_bit(8'h81, i / 4), 2'b10}) begin
                n_fail++;
                $display("FAIL slow_81 cycle %0d: bit/busy/sent=%b expected %b", i, {b2, y2, t2}, {frame_bit(8'h81, i / 4), 2'b10});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({b2, y2, t2, r2} !== 4'b1011) begin
            n_fail++;
            $display("FAIL slow_81_done: bit/busy/sent/ready=%b expected 1011", {b2, y2, t2, r2});
        end
        @(negedge clk);
        n_checks++;
        if (t2 !== 1'b0) begin
            n_fail++;
            $display("FAIL slow_81_pulse_width: sent_byte=%b expected 0", t2);
        end
    endtask

    task automatic test_back_to_back();
        logic       cap [64];
        logic       snt [64];
        logic [7:0] rx [4];
        logic [7:0] byte_v;
        int         pos;
        int         nbytes;
        d1 = 8'h3C; s1 = 1'b1;
        @(negedge clk);
        d1 = 8'hFF;
        for (int c = 0; c < 2 * LEN1 + 2; c++) begin
            cap[c] = b1;
            snt[c] = t1;
            if (c == LEN1 + 1) s1 = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if ({cap[LEN1], snt[LEN1], cap[LEN1 + 1]} !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_gap: bit/sent at gap, next bit=%b expected 110", {cap[LEN1], snt[LEN1], cap[LEN1 + 1]});
        end
        n_checks++;
        if (snt[2 * LEN1 + 1] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_sent: sent_byte=%b expected 1", snt[2 * LEN1 + 1]);
        end
        pos = 0; nbytes = 0;
        while (pos < 2 * LEN1 + 2 && nbytes < 4) begin
            if (cap[pos] === 1'b0) begin
                for (int k = 0; k < 8; k++) byte_v[7 - k] = cap[pos + 1 + k];
                rx[nbytes] = byte_v;
                nbytes++;
                pos += 9 + PAR;
            end else begin
                pos++;
            end
        end
        n_checks++;
        if (nbytes !== 2) begin
            n_fail++;
            $display("FAIL b2b_frame_count: got %0d frames expected 2", nbytes);
        end else begin
            n_checks++;
            if ({rx[0], rx[1]} !== 16'h3CFF) begin
                n_fail++;
                $display("FAIL b2b_loopback: got %h %h expected 3c ff", rx[0], rx[1]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int pulses;
        d1 = 8'h55; s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({b1, y1} !== {frame_bit(8'h55, 4), 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_pre: bit/busy=%b expected %b", {b1, y1}, {frame_bit(8'h55, 4), 1'b1});
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({b1, y1, t1, r1} !== 4'b1001) begin
            n_fail++;
            $display("FAIL midrst_immediate: bit/busy/sent/ready=%b expected 1001", {b1, y1, t1, r1});
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (t1 !== 1'b0 || b1 !== 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL midrst_abandon: %0d cycles with sent_byte or line low, expected 0", pulses);
        end
        d1 = 8'h55; s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        for (int i = 0; i < LEN1; i++) begin
            n_checks++;
            if ({b1, y1, t1} !== {frame_bit(8'h55, i), 2'b10}) begin
                n_fail++;
                $display("FAIL midrst_resend cycle %0d: bit/busy/sent=%b expected %b", i, {b1, y1, t1}, {frame_bit(8'h55, i), 2'b10});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({b1, y1, t1, r1} !== 4'b1011) begin
            n_fail++;
            $display("FAIL midrst_resend_done: bit/busy/sent/ready=%b expected 1011", {b1, y1, t1, r1});
        end
        @(negedge clk);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals [2];
        logic       par_exp [2];
        vals[0] = 8'h07; par_exp[0] = 1'b1;
        vals[1] = 8'h03; par_exp[1] = 1'b0;
        for (int v = 0; v < 2; v++) begin
            d1 = vals[v]; s1 = 1'b1;
            @(negedge clk);
            s1 = 1'b0;
            for (int i = 0; i < 11; i++) begin
                if (i == 9) begin
                    n_checks++;
                    if (b1 !== par_exp[v]) begin
                        n_fail++;
                        $display("FAIL parity_%h: parity bit=%b expected %b", vals[v], b1, par_exp[v]);
                    end
                end
                n_checks++;
                if ({y1, t1} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL parity_len_%h cycle %0d: busy/sent=%b expected 10", vals[v], i, {y1, t1});
                end
                @(negedge clk);
            end
            n_checks++;
            if ({b1, y1, t1, r1} !== 4'b1011) begin
                n_fail++;
                $display("FAIL parity_done_%h: bit/busy/sent/ready=%b expected 1011", vals[v], {b1, y1, t1, r1});
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default_frame();
        test_slow_frame();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises one byte per request onto a single line. Frame: start bit (0), 8 data bits MSB-first, then STOP_BITS stop bits (1).
- Transmit end of the UART link. The default frame and timing match uart_receiver: 1 clock per bit, start-bit detect on 0, MSB shifted in first.
- Accepts bytes through a valid/ready handshake, reports busy, and pulses once when each frame completes.

Parameters:
- CLKS_PER_BIT, 1, clock cycles each bit is held on bit_out; legal range 1..65535.
- STOP_BITS, 1, number of stop bits per frame; legal range 1..4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; one clock; asynchronous, active-high.
- data_in  input  8  byte to transmit; sampled only on the accepting edge.
- send_byte  input  1  request/valid; a byte is accepted on a rising edge where send_byte && ready.
- ready  output  1  high when a byte can be accepted (state IDLE).
- bit_out  output  1  serial line; idle level 1; registered output.
- busy  output  1  high from the first cycle of the start bit through the last cycle of the last stop bit.
- sent_byte  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (async, at any time, including mid-frame) takes effect immediately:
  - state=IDLE, bit_out=1, busy=0, sent_byte=0, ready=1;
  - shift register and counters cleared;
  - any partial frame is abandoned, with no sent_byte pulse.
- State IDLE: ready=1, busy=0, bit_out=1.
  - On an edge with send_byte=1, load data_in into the shift register and go to START.
  - On the cycle after that edge, bit_out=0 and busy=1.
- State START: bit_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 7.
- State DATA: bit_out = shift_reg[7], each bit held CLKS_PER_BIT cycles.
  - At each bit boundary, shift left by 1.
  - After 8 bits, go to STOP.
  - Order on the wire: data_in[7] first, data_in[0] last.
- State STOP: bit_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final edge, go to IDLE and assert sent_byte for exactly the following cycle.
  - In that cycle busy=0 and ready=1.
- Frame length: (9+STOP_BITS)*CLKS_PER_BIT cycles of busy=1. Default is 10 cycles.
- Back-to-back transmission:
  - If send_byte=1 during the sent_byte cycle, the new byte is accepted on that edge.
  - The next start bit starts the following cycle.
  - The only gap between frames is that single IDLE cycle at bit_out=1.
- send_byte while ready=0 is ignored. No queuing and no error.
- data_in changes after acceptance have no effect on the frame in progress.
- Bit-period counter: width clog2(CLKS_PER_BIT)+1, reset to 0 at every bit boundary. No wrap-around inside a bit.
- CLKS_PER_BIT=1: each state advances every cycle, with no counter stall.
- sent_byte and a new acceptance can occur in the same cycle. Both take effect: the pulse is emitted and the new frame starts.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - one parity bit is inserted between data bit 0 and the first stop bit, held CLKS_PER_BIT cycles;
  - even parity: XOR of the 8 data bits;
  - new state PARITY between DATA and STOP;
  - frame length becomes (10+STOP_BITS)*CLKS_PER_BIT.
- Undefined: no PARITY state or logic; frame exactly as above.
- The stock uart_receiver has no parity support. The macro stays undefined wherever that receiver is the far end.

Test Plan:
- Reset, then idle 5 cycles -> bit_out=1, ready=1, busy=0, sent_byte=0 throughout.
- Defaults; send 0xA5 one cycle -> bit_out sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles; busy=1 for those 10; sent_byte pulses on cycle 11 with ready=1.
- CLKS_PER_BIT=4, STOP_BITS=2; send 0x81 -> each bit held 4 cycles: 0,1,0,0,0,0,0,0,1,1,1; busy=1 for 44 cycles; one sent_byte pulse.
- Defaults, send_byte held high with data_in 0x3C then 0xFF -> two frames separated by exactly one idle-1 cycle; loopback into uart_receiver yields data_out 0x3C then 0xFF.
- Defaults; assert rst on the 4th data bit of 0x55 -> bit_out=1 immediately (before the next clk edge), busy=0, no sent_byte; a subsequent 0x55 transmits a correct frame.
- UART_TX_PARITY_EN defined; send 0x07 -> parity bit 1 after data bit 0; send 0x03 -> parity bit 0; frame length 11 cycles.
